cmd_pwm_hub: RTL



---
 rtl/cmd_pwm_hub.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cmd_pwm_hub.sv
// cmd_pwm_hub: parses AA 55 CMD LEN PAYLOAD CHK frames into NUM_CH double-buffered PWM channels + LED; CMD_PWM_HUB_TIMEOUT_EN adds an inter-byte timeout.
// Latency: frame_ok/frame_err one cycle after the CHK (or oversized LEN) byte; new period/duty take effect at the next counter wrap.
// Backpressure: none; one byte per cycle is always accepted.
module cmd_pwm_hub #(
  parameter int NUM_CH      = 8,
  parameter int PWM_W       = 16,
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        uart_rx_data_in,
  input  logic              uart_rx_data_valid_in,
  output logic [NUM_CH-1:0] pwm_pins,
  output logic              led_out,
  output logic              frame_ok,
  output logic              frame_err
);
  localparam int PWM_B   = PWM_W / 8;
  localparam int SET_LEN = 1 + 2 * PWM_B;
  localparam int EN_LEN  = (NUM_CH + 7) / 8;
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR2, S_CMD, S_LEN, S_PAYLOAD, S_CHK} state_t;

  state_t            state, state_nxt;
  logic              rx_vld;
  logic [7:0]        rx_dat;
  logic [7:0]        cmd_q, len_q, rem_q, sum_q;
  logic [IDX_W-1:0]  wr_idx;
  logic [7:0]        pay [MAX_LEN];
  logic [NUM_CH-1:0] en_q, new_en;
  logic [PWM_W-1:0]  new_per, new_duty;
  logic              ok_nxt, err_nxt, apply_set, apply_en, apply_led, timeout;
  logic [PWM_W-1:0]  per_sh [NUM_CH];
  logic [PWM_W-1:0]  duty_sh [NUM_CH];
  logic [PWM_W-1:0]  per_act [NUM_CH];
  logic [PWM_W-1:0]  duty_act [NUM_CH];
  logic [PWM_W-1:0]  cnt [NUM_CH];

  assign rx_vld = uart_rx_data_valid_in;
  assign rx_dat = uart_rx_data_in;

  // Payload fields are big-endian; enable byte k carries channels 8k+7..8k.
  always_comb begin
    new_per  = '0;
    new_duty = '0;
    new_en   = '0;
    for (int k = 0; k < PWM_B; k++) begin
      new_per  = new_per  | (PWM_W'(pay[1 + k])         << (8 * (PWM_B - 1 - k)));
      new_duty = new_duty | (PWM_W'(pay[1 + PWM_B + k]) << (8 * (PWM_B - 1 - k)));
    end
    for (int i = 0; i < NUM_CH; i++) new_en[i] = pay[i / 8][i % 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    apply_set = 1'b0;
    apply_en  = 1'b0;
    apply_led = 1'b0;
    if (timeout) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end else if (rx_vld) begin
      case (state)
        S_IDLE:    if (rx_dat == 8'hAA) state_nxt = S_HDR2;
        S_HDR2: begin
          if (rx_dat == 8'h55)      state_nxt = S_CMD;
          else if (rx_dat != 8'hAA) state_nxt = S_IDLE;
        end
        S_CMD:     state_nxt = S_LEN;
        S_LEN: begin
          if (rx_dat > 8'(MAX_LEN)) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
          end else if (rx_dat == 8'd0) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (rem_q == 8'd1) state_nxt = S_CHK;
        S_CHK: begin
          state_nxt = S_IDLE;
          if (rx_dat != sum_q) begin
            err_nxt = 1'b1;
          end else begin
            case (cmd_q)
              8'h01: begin
                if (len_q == 8'(SET_LEN) && pay[0] < 8'(NUM_CH)) apply_set = 1'b1;
                else                                              err_nxt   = 1'b1;
              end
              8'h02: begin
                if (len_q == 8'(EN_LEN)) apply_en = 1'b1;
                else                     err_nxt  = 1'b1;
              end
              8'h03: begin
                if (len_q == 8'd1) apply_led = 1'b1;
                else               err_nxt   = 1'b1;
              end
              default: err_nxt = 1'b1;
            endcase
            ok_nxt = apply_set | apply_en | apply_led;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      sum_q     <= '0;
      wr_idx    <= '0;
      en_q      <= '0;
      led_out   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
      if (rx_vld) begin
        case (state)
          S_CMD: begin
            cmd_q <= rx_dat;
            sum_q <= rx_dat;
          end
          S_LEN: begin
            len_q  <= rx_dat;
            rem_q  <= rx_dat;
            sum_q  <= sum_q + rx_dat;
            wr_idx <= '0;
          end
          S_PAYLOAD: begin
            rem_q  <= rem_q - 8'd1;
            sum_q  <= sum_q + rx_dat;
            wr_idx <= wr_idx + IDX_W'(1);
          end
          default: ;
        endcase
      end
      if (apply_en)  en_q    <= new_en;
      if (apply_led) led_out <= pay[0][0];
    end
  end

  always_ff @(posedge clk) begin
    if (rx_vld && state == S_PAYLOAD) pay[wr_idx] <= rx_dat;
  end

  // Active registers reload from shadow only at wrap or while disabled, so a period never gets cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        per_sh[i]   <= '0;
        duty_sh[i]  <= '0;
        per_act[i]  <= '0;
        duty_act[i] <= '0;
        cnt[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply_set && pay[0] == 8'(i)) begin
          per_sh[i]  <= new_per;
          duty_sh[i] <= new_duty;
        end
        if (!en_q[i] || cnt[i] >= per_act[i]) begin
          cnt[i]      <= '0;
          per_act[i]  <= per_sh[i];
          duty_act[i] <= duty_sh[i];
        end else begin
          cnt[i] <= cnt[i] + PWM_W'(1);
        end
      end
    end
  end

  always_comb begin
    pwm_pins = '0;
    for (int i = 0; i < NUM_CH; i++) pwm_pins[i] = en_q[i] & (cnt[i] < duty_act[i]);
  end

`ifdef CMD_PWM_HUB_TIMEOUT_EN
  logic [31:0] idle_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     idle_cyc <= '0;
    else if (rx_vld || state == S_IDLE || timeout)  idle_cyc <= '0;
    else                                            idle_cyc <= idle_cyc + 32'd1;
  end

  assign timeout = (state != S_IDLE) && !rx_vld && (idle_cyc == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule
